// File: rtl/chrom_eval_fsm.sv
// chrom_eval_fsm: chromosome fitness-evaluation controller.
// Drives a stimulus set through an external phenotype and counts per-output-bit
// mismatches. Clean passes are re-run iRetries extra times. Results are
// presented with a start/done/ack handshake.
// Optional trace write port: define CHROM_EVAL_TRACE_EN to enable it; otherwise
// the trace outputs are tied to zero.
module chrom_eval_fsm #(
    parameter int IN_BITS       = 8,
    parameter int OUT_BITS      = 8,
    parameter int IDX_BITS      = 8,
    parameter int CNT_W         = 32,
    parameter int CYC_W         = 16,
    parameter int IGNORE_CYCLES = 10,
    parameter int ADDR_W        = 15
) (
    input  logic                                  iClock,
    input  logic                                  iReset_n,
    input  logic                                  iStart,
    input  logic                                  iAck,
    input  logic [IDX_BITS-1:0]                   iSeqCount,
    input  logic [CYC_W-1:0]                      iCyclesPerInput,
    input  logic [3:0]                            iRetries,
    input  logic                                  iAbortOnError,
    output logic [IDX_BITS-1:0]                   oSeqIndex,
    input  logic [IN_BITS-1:0]                    iSeqInput,
    input  logic [OUT_BITS-1:0]                   iSeqExpected,
    input  logic [OUT_BITS-1:0]                   iSeqValid,
    output logic [IN_BITS-1:0]                    oChromInput,
    input  logic [OUT_BITS-1:0]                   iChromOutput,
    output logic                                  oZeroChrom,
    output logic                                  oReady,
    output logic                                  oDone,
    output logic                                  oPass,
    output logic                                  oAborted,
    output logic                                  oCfgError,
    output logic [OUT_BITS*CNT_W-1:0]             oErrorSums,
    output logic [CNT_W+$clog2(OUT_BITS)-1:0]     oErrorTotal,
    output logic [3:0]                            oRetry,
    output logic                                  oTraceWe,
    output logic [ADDR_W-1:0]                     oTraceAddr,
    output logic [IN_BITS+IDX_BITS+2*OUT_BITS-1:0] oTraceData
);

    localparam int TOT_W = CNT_W + $clog2(OUT_BITS);
    localparam logic [CYC_W-1:0] IGN = CYC_W'(IGNORE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [IDX_BITS-1:0]                idx;
    logic [3:0]                         retry;
    logic [CYC_W-1:0]                   cyc;
    logic [OUT_BITS-1:0]                flags;
    logic [OUT_BITS-1:0][CNT_W-1:0]     sums;
    logic                               pass;
    logic                               aborted;
    logic                               cfg_err;
    logic [IN_BITS-1:0]                 chrom_in_p1;
    logic [TOT_W-1:0]                   total;

    logic [OUT_BITS-1:0] mis;
    logic [OUT_BITS-1:0] commit_bits;
    logic                cfg_bad;
    logic                at_commit;
    logic                last_vec;
    logic                new_err;

    logic do_start, do_commit, do_next, do_abort, do_retry, do_pass;
    logic ready, done, zero_chrom;

    // Saturating increment: a counter pinned at all-ones stays there.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             inc);
        if (inc && (v != {CNT_W{1'b1}}))
            return v + 1'b1;
        return v;
    endfunction

    assign mis         = (iChromOutput ^ iSeqExpected) & iSeqValid;
    assign commit_bits = flags | mis;
    assign cfg_bad     = (iSeqCount == '0) || (iCyclesPerInput <= IGN);
    assign at_commit   = (cyc == iCyclesPerInput - 1'b1);
    assign last_vec    = (idx == iSeqCount - 1'b1);
    // Total after this commit is non-zero if it already was, or if any bit
    // is about to be counted (a saturated counter is already non-zero).
    assign new_err     = (total != '0) || (|commit_bits);

    // Sum of per-bit counters, combinational from the registered sums.
    always_comb begin
        total = '0;
        for (int i = 0; i < OUT_BITS; i++)
            total = total + TOT_W'(sums[i]);
    end

    // State register.
    always_ff @(posedge iClock) begin
        if (!iReset_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode plus the control strobes and state-derived status.
    always_comb begin
        state_nxt  = state;
        do_start   = 1'b0;
        do_commit  = 1'b0;
        do_next    = 1'b0;
        do_abort   = 1'b0;
        do_retry   = 1'b0;
        do_pass    = 1'b0;
        ready      = 1'b0;
        done       = 1'b0;
        zero_chrom = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (iStart && !cfg_bad) begin
                    do_start  = 1'b1;
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                zero_chrom = 1'b1;
                state_nxt  = S_RUN;
            end
            S_RUN: begin
                if (at_commit) begin
                    do_commit = 1'b1;
                    if (iAbortOnError && new_err) begin
                        do_abort  = 1'b1;
                        state_nxt = S_DONE;
                    end else if (last_vec) begin
                        state_nxt = S_CHECK;
                    end else begin
                        do_next = 1'b1;
                    end
                end
            end
            S_CHECK: begin
                if (total != '0) begin
                    state_nxt = S_DONE;
                end else if (retry < iRetries) begin
                    do_retry  = 1'b1;
                    state_nxt = S_RUN;
                end else begin
                    do_pass   = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (iAck)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: stimulus register, cycle counter, sticky flags, sums, index.
    always_ff @(posedge iClock) begin
        if (!iReset_n) begin
            idx         <= '0;
            retry       <= '0;
            cyc         <= '0;
            flags       <= '0;
            sums        <= '0;
            pass        <= 1'b0;
            aborted     <= 1'b0;
            cfg_err     <= 1'b0;
            chrom_in_p1 <= '0;
        end else begin
            // stage p1: stimulus lags the ROM index by one cycle
            chrom_in_p1 <= iSeqInput;
            cfg_err     <= (state == S_IDLE) && iStart && cfg_bad;

            if (do_start) begin
                sums    <= '0;
                idx     <= '0;
                retry   <= '0;
                pass    <= 1'b0;
                aborted <= 1'b0;
            end

            if (state == S_CLEAR) begin
                cyc   <= '0;
                flags <= '0;
            end

            if (state == S_RUN) begin
                if (do_commit) begin
                    for (int i = 0; i < OUT_BITS; i++)
                        sums[i] <= sat_inc(sums[i], commit_bits[i]);
                    cyc   <= '0;
                    flags <= '0;
                    if (do_next)
                        idx <= idx + 1'b1;
                end else begin
                    cyc <= cyc + 1'b1;
                    if (cyc >= IGN)
                        flags <= flags | mis;
                end
            end

            if (do_abort)
                aborted <= 1'b1;
            if (do_pass)
                pass <= 1'b1;
            if (do_retry) begin
                retry <= retry + 1'b1;
                idx   <= '0;
            end
        end
    end

    assign oSeqIndex   = idx;
    assign oChromInput = chrom_in_p1;
    assign oZeroChrom  = zero_chrom;
    assign oReady      = ready;
    assign oDone       = done;
    assign oPass       = pass;
    assign oAborted    = aborted;
    assign oCfgError   = cfg_err;
    assign oErrorSums  = sums;
    assign oErrorTotal = total;
    assign oRetry      = retry;

`ifdef CHROM_EVAL_TRACE_EN
    logic [ADDR_W-1:0] trace_addr;

    // Trace address: restarts each pass so the buffer ends up holding the last one.
    always_ff @(posedge iClock) begin
        if (!iReset_n)
            trace_addr <= '0;
        else if ((state == S_CLEAR) || do_retry)
            trace_addr <= '0;
        else if (state == S_RUN)
            trace_addr <= trace_addr + 1'b1;
    end

    assign oTraceWe   = (state == S_RUN);
    assign oTraceAddr = trace_addr;
    assign oTraceData = {chrom_in_p1, idx, iSeqExpected, iChromOutput};
`else
    assign oTraceWe   = 1'b0;
    assign oTraceAddr = '0;
    assign oTraceData = '0;
`endif

endmodule

// File: tb/tb_chrom_eval_fsm.sv
// Testbench for chrom_eval_fsm: scoreboard of expected evaluation results,
// a monitor that checks them when oDone rises, and a behavioural phenotype.
module tb_chrom_eval_fsm;

    localparam int IN_BITS  = 8;
    localparam int OUT_BITS = 8;
    localparam int IDX_BITS = 8;
    localparam int CNT_W    = 32;
    localparam int CYC_W    = 16;
    localparam int IGN      = 10;
    localparam int ADDR_W   = 4;

    logic iClock = 1'b0;
    logic iReset_n = 1'b0;
    logic iStart = 1'b0;
    logic iAck = 1'b0;
    logic [IDX_BITS-1:0] iSeqCount = 8'd1;
    logic [CYC_W-1:0] iCyclesPerInput = 16'd20;
    logic [3:0] iRetries = 4'd0;
    logic iAbortOnError = 1'b0;
    logic [IDX_BITS-1:0] oSeqIndex;
    logic [IN_BITS-1:0] iSeqInput;
    logic [OUT_BITS-1:0] iSeqExpected, iSeqValid;
    logic [IN_BITS-1:0] oChromInput;
    logic [OUT_BITS-1:0] iChromOutput;
    logic oZeroChrom, oReady, oDone, oPass, oAborted, oCfgError;
    logic [OUT_BITS*CNT_W-1:0] oErrorSums;
    logic [CNT_W+2:0] oErrorTotal;
    logic [3:0] oRetry;
    logic oTraceWe;
    logic [ADDR_W-1:0] oTraceAddr;
    logic [31:0] oTraceData;

    chrom_eval_fsm #(
        .IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .IDX_BITS(IDX_BITS), .CNT_W(CNT_W),
        .CYC_W(CYC_W), .IGNORE_CYCLES(IGN), .ADDR_W(ADDR_W)
    ) dut (
        .iClock(iClock), .iReset_n(iReset_n), .iStart(iStart), .iAck(iAck),
        .iSeqCount(iSeqCount), .iCyclesPerInput(iCyclesPerInput), .iRetries(iRetries),
        .iAbortOnError(iAbortOnError), .oSeqIndex(oSeqIndex), .iSeqInput(iSeqInput),
        .iSeqExpected(iSeqExpected), .iSeqValid(iSeqValid), .oChromInput(oChromInput),
        .iChromOutput(iChromOutput), .oZeroChrom(oZeroChrom), .oReady(oReady),
        .oDone(oDone), .oPass(oPass), .oAborted(oAborted), .oCfgError(oCfgError),
        .oErrorSums(oErrorSums), .oErrorTotal(oErrorTotal), .oRetry(oRetry),
        .oTraceWe(oTraceWe), .oTraceAddr(oTraceAddr), .oTraceData(oTraceData)
    );

    always #5 iClock = ~iClock;

    int cycle = 0;
    always @(posedge iClock) cycle <= cycle + 1;

    // Stimulus ROM: input of vector k is k^5A so the phenotype can recover k.
    logic [7:0] rom_in[256], rom_exp[256], rom_val[256], rom_err[256];
    assign iSeqInput    = rom_in[oSeqIndex];
    assign iSeqExpected = rom_exp[oSeqIndex];
    assign iSeqValid    = rom_val[oSeqIndex];

    // Timed glitch injection relative to the run start.
    int g_t = 0, g_s = 1, g_n = 1;
    bit g_on = 0, g_m1 = 0, g_m5 = 0, tr_on = 0;
    int rr;
    logic [7:0] glitch;
    always_comb begin
        glitch = 8'h00;
        rr = cycle - g_t - 2;
        if (g_on && rr >= 0 && rr < g_s * g_n) begin
            if (g_m1 && (rr % g_n) < IGN) glitch[3] = 1'b1;
            if (g_m5 && (rr % g_n) == g_n - 1) glitch[5] = 1'b1;
        end
    end

    // Phenotype: correct answer for the applied vector, with its static fault.
    assign iChromOutput = rom_exp[oChromInput ^ 8'h5A] ^ rom_err[oChromInput ^ 8'h5A] ^ glitch;

    int n_checks = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int          done;
        bit          pass;
        bit          aborted;
        logic [255:0] sums;
        logic [34:0] total;
        logic [3:0]  retry;
    } exp_t;
    exp_t sb[$];

    // Reference: walk passes and vectors, counting one error per faulty valid bit.
    function automatic exp_t model(int t, int s, int n, int r, bit ab, bit m5);
        exp_t e;
        int cnt[8];
        int run, tot;
        bit stop;
        logic [7:0] bits;
        e.pass = 0; e.aborted = 0; e.retry = 0; e.sums = '0;
        run = 0; tot = 0; stop = 0;
        for (int i = 0; i < 8; i++) cnt[i] = 0;
        for (int p = 0; p <= r && !stop; p++) begin
            e.retry = 4'(p);
            for (int k = 0; k < s && !stop; k++) begin
                bits = (rom_err[k] | (m5 ? 8'h20 : 8'h00)) & rom_val[k];
                for (int i = 0; i < 8; i++) begin
                    cnt[i] += int'(bits[i]);
                    tot    += int'(bits[i]);
                end
                run += n;
                if (ab && tot > 0) begin
                    e.aborted = 1;
                    stop = 1;
                end
            end
            if (!stop) begin
                run += 1;
                if (tot > 0) stop = 1;
                else if (p == r) e.pass = 1;
            end
        end
        e.done  = t + 2 + run;
        e.total = 35'(tot);
        for (int i = 0; i < 8; i++) e.sums[i*32 +: 32] = 32'(cnt[i]);
        return e;
    endfunction

    // Monitor: compare results against the scoreboard when oDone rises.
    logic prev_done = 1'b0;
    always @(negedge iClock) begin
        if (oDone === 1'b1 && prev_done !== 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: oDone rose at cycle %0d, required no result pending", cycle);
            end else begin
                chk("done_latency", 256'(cycle), 256'(sb[0].done));
                chk("pass", 256'(oPass), 256'(sb[0].pass));
                chk("aborted", 256'(oAborted), 256'(sb[0].aborted));
                chk("error_sums", oErrorSums, sb[0].sums);
                chk("error_total", 256'(oErrorTotal), 256'(sb[0].total));
                chk("retry", 256'(oRetry), 256'(sb[0].retry));
                void'(sb.pop_front());
            end
        end
        prev_done <= oDone;
    end

    // Trace monitor: address and data fields during a traced run.
    int all_writes = 0;
    always @(negedge iClock) begin
        if (oTraceWe === 1'b1) begin
            all_writes <= all_writes + 1;
            if (tr_on) begin
                chk("trace_addr", 256'(oTraceAddr), 256'(rr % 16));
                chk("trace_idx", 256'(oTraceData[23:16]), 256'(rr / g_n));
                chk("trace_chrom", 256'(oTraceData[31:24]), 256'(rom_in[(rr == 0) ? 0 : (rr - 1) / g_n]));
                chk("trace_exp", 256'(oTraceData[15:8]), 256'(rom_exp[rr / g_n]));
                chk("trace_out", 256'(oTraceData[7:0]), 256'(iChromOutput));
            end
        end
    end

    task automatic set_rom(input logic [7:0] val_all, input bit rnd_val, input logic [7:0] err_all);
        for (int k = 0; k < 256; k++) begin
            rom_exp[k] = 8'($urandom);
            rom_val[k] = rnd_val ? 8'($urandom) : val_all;
            rom_err[k] = err_all;
        end
    endtask

    task automatic run_eval(input int s, input int n, input int r, input bit ab,
                            input bit m1, input bit m5, input bit tr);
        int w;
        @(negedge iClock);
        iSeqCount = 8'(s); iCyclesPerInput = 16'(n); iRetries = 4'(r); iAbortOnError = ab;
        g_t = cycle; g_s = s; g_n = n; g_m1 = m1; g_m5 = m5; g_on = 1; tr_on = tr;
        sb.push_back(model(cycle, s, n, r, ab, m5));
        iStart = 1'b1;
        @(negedge iClock);
        iStart = 1'b0;
        chk("zero_chrom_clear", 256'(oZeroChrom), 256'(1));
        @(negedge iClock);
        chk("zero_chrom_run", 256'(oZeroChrom), 256'(0));
        w = 0;
        while (oDone !== 1'b1 && w < 5000) begin
            @(negedge iClock);
            w++;
        end
        if (oDone !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: oDone=%b after %0d cycles, required 1", oDone, w);
            sb.delete();
            iReset_n = 1'b0;
            @(negedge iClock);
            iReset_n = 1'b1;
        end else begin
            @(negedge iClock);
            chk("done_held", 256'(oDone), 256'(1));
            iAck = 1'b1;
            @(negedge iClock);
            iAck = 1'b0;
            chk("ready_after_ack", 256'(oReady), 256'(1));
        end
        g_on = 0;
        tr_on = 0;
    endtask

    task automatic cfg_err_case(input int s, input int n);
        @(negedge iClock);
        iSeqCount = 8'(s); iCyclesPerInput = 16'(n); iRetries = 4'd0;
        iStart = 1'b1;
        @(negedge iClock);
        iStart = 1'b0;
        chk("cfg_error_pulse", 256'(oCfgError), 256'(1));
        chk("cfg_stays_idle", 256'(oReady), 256'(1));
        @(negedge iClock);
        chk("cfg_error_clears", 256'(oCfgError), 256'(0));
        chk("cfg_no_clear", 256'(oZeroChrom), 256'(0));
    endtask

    initial begin
        int w0;
        for (int k = 0; k < 256; k++) begin
            rom_in[k] = 8'(k) ^ 8'h5A;
            rom_exp[k] = 8'h00; rom_val[k] = 8'h00; rom_err[k] = 8'h00;
        end

        // Reset state
        repeat (3) @(negedge iClock);
        chk("rst_ready", 256'(oReady), 256'(1));
        chk("rst_done", 256'(oDone), 256'(0));
        chk("rst_pass", 256'(oPass), 256'(0));
        chk("rst_aborted", 256'(oAborted), 256'(0));
        chk("rst_cfgerr", 256'(oCfgError), 256'(0));
        chk("rst_zero", 256'(oZeroChrom), 256'(0));
        chk("rst_sums", oErrorSums, 256'(0));
        chk("rst_total", 256'(oErrorTotal), 256'(0));
        chk("rst_index", 256'(oSeqIndex), 256'(0));
        chk("rst_retry", 256'(oRetry), 256'(0));
        chk("rst_trace_we", 256'(oTraceWe), 256'(0));
        chk("rst_trace_addr", 256'(oTraceAddr), 256'(0));
        chk("rst_chrom_in", 256'(oChromInput), 256'(0));
        iReset_n = 1'b1;

        // Perfect phenotype, three clean passes
        set_rom(8'hFF, 0, 8'h00);
        run_eval(4, 20, 2, 0, 0, 0, 0);
        // Bit 3 always wrong: fails after the first pass
        set_rom(8'hFF, 0, 8'h08);
        run_eval(4, 20, 2, 0, 0, 0, 0);
        // Bit 3 wrong only inside the settle window: ignored
        set_rom(8'hFF, 0, 8'h00);
        run_eval(4, 20, 0, 0, 1, 0, 0);
        // Bit 5 wrong only on the commit cycle: one per vector
        run_eval(4, 20, 0, 0, 0, 1, 0);
        // Abort at the first committed error (vector 2 of 8)
        set_rom(8'hFF, 0, 8'h00);
        rom_err[2] = 8'h02;
        run_eval(8, 15, 0, 1, 0, 0, 0);

        // Configuration errors
        cfg_err_case(0, 20);
        cfg_err_case(4, IGN);

        // Traced run with address wrap
        set_rom(8'hFF, 0, 8'h00);
        w0 = all_writes;
        run_eval(2, 20, 0, 0, 0, 0, 1);
`ifdef CHROM_EVAL_TRACE_EN
        chk("trace_writes", 256'(all_writes - w0), 256'(40));
`else
        chk("trace_writes", 256'(all_writes - w0), 256'(0));
`endif

        // Randomised configurations
        for (int it = 0; it < 10; it++) begin
            bit clean;
            clean = 1'($urandom_range(0, 1));
            set_rom(8'h00, 1, 8'h00);
            if (!clean)
                for (int k = 0; k < 256; k++)
                    rom_err[k] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            run_eval($urandom_range(1, 6), $urandom_range(11, 25), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), 0, 0, 0);
        end

        // Reset in the middle of a run with errors already counted
        set_rom(8'hFF, 0, 8'h08);
        @(negedge iClock);
        iSeqCount = 8'd4; iCyclesPerInput = 16'd20; iRetries = 4'd0; iAbortOnError = 1'b0;
        iStart = 1'b1;
        @(negedge iClock);
        iStart = 1'b0;
        repeat (30) @(negedge iClock);
        chk("midrun_sum_before_reset", 256'(oErrorTotal), 256'(1));
        iReset_n = 1'b0;
        @(negedge iClock);
        chk("midrun_rst_ready", 256'(oReady), 256'(1));
        chk("midrun_rst_total", 256'(oErrorTotal), 256'(0));
        chk("midrun_rst_sums", oErrorSums, 256'(0));
        chk("midrun_rst_done", 256'(oDone), 256'(0));
        chk("midrun_rst_index", 256'(oSeqIndex), 256'(0));
        chk("midrun_rst_trace_we", 256'(oTraceWe), 256'(0));
        iReset_n = 1'b1;
        repeat (3) @(negedge iClock);
        chk("midrun_idle_after", 256'(oReady), 256'(1));

        chk("scoreboard_drained", 256'(sb.size()), 256'(0));
`ifndef CHROM_EVAL_TRACE_EN
        chk("no_trace_writes", 256'(all_writes), 256'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
